// File: rtl/conv_l1_sched.sv
// conv_l1_sched: frame sequencer for the first conv layer.
//
// Each frame runs REUSE passes. A pass loads LEN*LEN weight beats from the
// weight RAM, waits for the last beat to leave the RAM pipeline, and then
// streams SIZE*SIZE input windows to the conv layer with vsync/hsync/reuse
// framing. After the last window it idles DRAIN cycles so the conv pipeline
// can flush before the next pass overwrites the weights.
//
// Ports
//   i_sclk, i_rst        clock, synchronous active-high reset
//   i_start              frame start pulse (ignored while busy or in DONE)
//   o_busy, o_done       busy from accepted start until done; done one-cycle pulse
//   o_wt_rd, o_wt_addr   weight RAM read request (data returns one cycle later)
//   i_wt_data            weight RAM read data
//   i_win_valid,
//   o_win_ready,
//   i_win_tdata          window source handshake and data
//   o_cw_vld, o_cw       weight beat to the conv layer
//   o_vsync, o_hsync,
//   o_reuse, o_valid,
//   o_tdata              window stream and framing to the conv layer
module conv_l1_sched #(
  parameter int WIDTH_D = 24,
  parameter int WIDTH_W = 20,
  parameter int SIZE    = 112,
  parameter int THREAD  = 2,
  parameter int REUSE   = 32,
  parameter int LEN     = 7,
  parameter int DRAIN   = 16,
  parameter int AW      = $clog2(REUSE*LEN*LEN)
) (
  input  logic                          i_sclk,
  input  logic                          i_rst,
  input  logic                          i_start,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_wt_rd,
  output logic [AW-1:0]                 o_wt_addr,
  input  logic [WIDTH_W*3*THREAD-1:0]   i_wt_data,
  input  logic                          i_win_valid,
  output logic                          o_win_ready,
  input  logic [WIDTH_D*LEN*LEN-1:0]    i_win_tdata,
  output logic                          o_cw_vld,
  output logic [WIDTH_W*3*THREAD-1:0]   o_cw,
  output logic                          o_vsync,
  output logic                          o_hsync,
  output logic                          o_reuse,
  output logic                          o_valid,
  output logic [WIDTH_D*LEN*LEN-1:0]    o_tdata
);

  localparam int TAPS = LEN*LEN;
  localparam int PW   = (REUSE > 1) ? $clog2(REUSE) : 1;
  localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int SW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW   = ($clog2(DRAIN) > 1) ? $clog2(DRAIN) : 1;

  localparam logic [PW-1:0] PASS_LAST  = PW'(REUSE-1);
  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS-1);
  localparam logic [SW-1:0] POS_LAST   = SW'(SIZE-1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'(1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN-1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_WAIT_W, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pass;
  logic [TW-1:0] tap;
  logic [SW-1:0] row, col;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr;
  logic          xfer;
  logic          last_win;
  logic          vld_p0;

  // Pass address ranges are contiguous, so a single running address that only
  // clears in IDLE produces pass*LEN*LEN + tap without a multiplier.
  assign xfer     = i_win_valid & o_win_ready;
  assign last_win = (row == POS_LAST) && (col == POS_LAST);

  always_ff @(posedge i_sclk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    o_wt_rd     = 1'b0;
    o_wt_addr   = '0;
    o_win_ready = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        o_wt_rd   = 1'b1;
        o_wt_addr = addr;
        if (tap == TAP_LAST) state_nxt = S_WAIT_W;
      end
      S_WAIT_W: begin
        if (cnt == WAIT_LAST) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        o_win_ready = 1'b1;
        if (i_win_valid && last_win) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) state_nxt = (pass == PASS_LAST) ? S_DONE : S_LOAD_W;
      end
      S_DONE: begin
        o_busy    = 1'b0;
        o_done    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      pass <= '0;
      tap  <= '0;
      row  <= '0;
      col  <= '0;
      cnt  <= '0;
      addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          pass <= '0;
          tap  <= '0;
          row  <= '0;
          col  <= '0;
          cnt  <= '0;
          addr <= '0;
        end
        S_LOAD_W: begin
          addr <= addr + AW'(1);
          tap  <= (tap == TAP_LAST) ? '0 : tap + TW'(1);
          cnt  <= '0;
        end
        S_WAIT_W: begin
          cnt <= (cnt == WAIT_LAST) ? '0 : cnt + CW'(1);
        end
        S_STREAM: begin
          if (xfer) begin
            if (col == POS_LAST) begin
              col <= '0;
              row <= (row == POS_LAST) ? '0 : row + SW'(1);
            end else begin
              col <= col + SW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt <= '0;
            if (pass != PASS_LAST) pass <= pass + PW'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // p0: read request delayed to line up with RAM data; p1: beat to conv layer.
  // Reset clears vld_p0, which discards any RAM read still in flight.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      vld_p0   <= 1'b0;
      o_cw_vld <= 1'b0;
      o_cw     <= '0;
    end else begin
      vld_p0   <= o_wt_rd;
      o_cw_vld <= vld_p0;
      if (vld_p0) o_cw <= i_wt_data;
    end
  end

  // Window output stage: one register between source handshake and conv layer.
  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_vsync <= 1'b0;
      o_hsync <= 1'b0;
      o_reuse <= 1'b0;
      o_tdata <= '0;
    end else begin
      o_valid <= xfer;
      o_vsync <= xfer && (row == '0) && (col == '0);
      o_hsync <= xfer && (col == '0);
      o_reuse <= xfer && (pass != '0);
      if (xfer) o_tdata <= i_win_tdata;
    end
  end

endmodule

// File: tb/tb_conv_l1_sched.sv
module tb_conv_l1_sched;

  localparam int SIZE = 4, REUSE = 2, LEN = 3, DRAIN = 4, THREAD = 2;
  localparam int WD = 8, WW = 8;
  localparam int TD = WD*LEN*LEN;       // 72
  localparam int TW = WW*3*THREAD;      // 48
  localparam int AW = 5;
  localparam logic [TD-1:0] TBASE = 72'h5A_0000_0000_0000_1000;

  logic          clk;
  logic          i_rst, i_start, i_win_valid;
  logic [TD-1:0] i_win_tdata;
  logic [TW-1:0] wt_data;
  logic          o_busy, o_done, o_wt_rd, o_win_ready, o_cw_vld;
  logic          o_vsync, o_hsync, o_reuse, o_valid;
  logic [AW-1:0] o_wt_addr;
  logic [TW-1:0] o_cw;
  logic [TD-1:0] o_tdata;

  // default-parameter instance
  logic           d_rst, d_start;
  logic [119:0]   d_wt_data;
  logic [1175:0]  d_win_tdata;
  logic           d_busy, d_done, d_rd, d_ready, d_cw_vld, d_vsync, d_hsync, d_reuse, d_valid;
  logic [10:0]    d_addr;
  logic [119:0]   d_cw;
  logic [1175:0]  d_tdata;

  int checks = 0;
  int failures = 0;

  conv_l1_sched #(.WIDTH_D(WD), .WIDTH_W(WW), .SIZE(SIZE), .THREAD(THREAD),
                  .REUSE(REUSE), .LEN(LEN), .DRAIN(DRAIN)) dut (
    .i_sclk(clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
    .o_wt_rd(o_wt_rd), .o_wt_addr(o_wt_addr), .i_wt_data(wt_data),
    .i_win_valid(i_win_valid), .o_win_ready(o_win_ready), .i_win_tdata(i_win_tdata),
    .o_cw_vld(o_cw_vld), .o_cw(o_cw), .o_vsync(o_vsync), .o_hsync(o_hsync),
    .o_reuse(o_reuse), .o_valid(o_valid), .o_tdata(o_tdata));

  conv_l1_sched dut_d (
    .i_sclk(clk), .i_rst(d_rst), .i_start(d_start), .o_busy(d_busy), .o_done(d_done),
    .o_wt_rd(d_rd), .o_wt_addr(d_addr), .i_wt_data(d_wt_data),
    .i_win_valid(1'b0), .o_win_ready(d_ready), .i_win_tdata(d_win_tdata),
    .o_cw_vld(d_cw_vld), .o_cw(d_cw), .o_vsync(d_vsync), .o_hsync(d_hsync),
    .o_reuse(d_reuse), .o_valid(d_valid), .o_tdata(d_tdata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TW-1:0] ram_f(input logic [AW-1:0] a);
    return {8'hC3, 3'b000, a, 32'hBEEF_0000 + 32'(a) * 32'h0000_0101};
  endfunction

  // weight RAM model: registered read, data valid the cycle after rd
  always @(posedge clk) if (o_wt_rd) wt_data <= ram_f(o_wt_addr);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_win_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"},  128'(o_busy), 128'(0));
    chk({tag, "_done"},  128'(o_done), 128'(0));
    chk({tag, "_rd"},    128'(o_wt_rd), 128'(0));
    chk({tag, "_addr"},  128'(o_wt_addr), 128'(0));
    chk({tag, "_ready"}, 128'(o_win_ready), 128'(0));
    chk({tag, "_cwvld"}, 128'(o_cw_vld), 128'(0));
    chk({tag, "_cw"},    128'(o_cw), 128'(0));
    chk({tag, "_valid"}, 128'(o_valid), 128'(0));
    chk({tag, "_strb"},  128'({o_vsync, o_hsync, o_reuse}), 128'(0));
    chk({tag, "_tdata"}, 128'(o_tdata), 128'(0));
  endtask

  // Runs one frame from an IDLE negedge. poke_at: cycle to re-pulse i_start
  // (-1 none). abort_at: valid count at which reset is applied (-1 none).
  task automatic run_frame(input string tag, input bit bp, input int poke_at, input int abort_at);
    int vcnt = 0, rdcnt = 0, cwcnt = 0, vs = 0, hs = 0, rs = 0, dn = 0, src = 0;
    int last_vcyc = 0;
    bit rd_d1 = 0, rd_d2 = 0, xfer_prev = 0, fin = 0;
    logic [AW-1:0] a_d1 = '0, a_d2 = '0, exp_addr = '0, last_addr = '0;
    i_start = 1'b1;
    i_win_tdata = TBASE;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      i_start = (cyc == poke_at);
      if (cyc == 0) chk({tag, "_busy_after_start"}, 128'(o_busy), 128'(1));
      if (xfer_prev) src++;
      chk({tag, "_valid_vs_xfer"}, 128'(o_valid), 128'(xfer_prev));
      if (o_valid) begin
        if (vcnt == 0 && !bp) chk({tag, "_first_valid_cyc"}, 128'(cyc), 128'(12));
        chk({tag, "_tdata"}, 128'(o_tdata), 128'(TBASE + TD'(vcnt)));
        chk({tag, "_vsync"}, 128'(o_vsync), 128'((vcnt % 16) == 0));
        chk({tag, "_hsync"}, 128'(o_hsync), 128'((vcnt % 4) == 0));
        chk({tag, "_reuse"}, 128'(o_reuse), 128'(vcnt >= 16));
        vs += int'(o_vsync); hs += int'(o_hsync); rs += int'(o_reuse);
        vcnt++;
        last_vcyc = cyc;
      end else begin
        chk({tag, "_strobes_idle"}, 128'({o_vsync, o_hsync, o_reuse}), 128'(0));
      end
      if (o_wt_rd) begin
        chk({tag, "_addr"}, 128'(o_wt_addr), 128'(exp_addr));
        if (exp_addr == 5'd9) chk({tag, "_drain_gap"}, 128'(cyc - last_vcyc), 128'(DRAIN));
        last_addr = o_wt_addr;
        exp_addr++;
        rdcnt++;
      end
      chk({tag, "_cw_vld"}, 128'(o_cw_vld), 128'(rd_d2));
      if (rd_d2) begin
        chk({tag, "_cw"}, 128'(o_cw), 128'(ram_f(a_d2)));
        cwcnt++;
      end
      rd_d2 = rd_d1; a_d2 = a_d1; rd_d1 = o_wt_rd; a_d1 = o_wt_addr;
      if (o_done) begin
        dn++;
        chk({tag, "_busy_at_done"}, 128'(o_busy), 128'(0));
        chk({tag, "_done_gap"}, 128'(cyc - last_vcyc), 128'(DRAIN));
        fin = 1;
      end
      if (abort_at >= 0 && vcnt == abort_at) begin
        i_rst = 1'b1;
        i_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        all_zero({tag, "_after_rst"});
        i_rst = 1'b0;
        i_start = 1'b0;
        return;
      end
      i_win_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      i_win_tdata = TBASE + TD'(src);
      xfer_prev = i_win_valid & o_win_ready;
    end
    i_start = 1'b0;
    if (!fin) chk({tag, "_timeout"}, 128'(0), 128'(1));
    chk({tag, "_rd_count"}, 128'(rdcnt), 128'(18));
    chk({tag, "_last_addr"}, 128'(last_addr), 128'(17));
    chk({tag, "_cw_count"}, 128'(cwcnt), 128'(18));
    chk({tag, "_valid_count"}, 128'(vcnt), 128'(32));
    chk({tag, "_vsync_count"}, 128'(vs), 128'(2));
    chk({tag, "_hsync_count"}, 128'(hs), 128'(8));
    chk({tag, "_reuse_count"}, 128'(rs), 128'(16));
    chk({tag, "_done_count"}, 128'(dn), 128'(1));
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_win_valid = 1'b0; i_win_tdata = '0;
    d_rst = 1'b1; d_start = 1'b0; d_wt_data = '0; d_win_tdata = '0;

    // reset with random inputs
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      i_start = 1'($urandom_range(0, 1));
      i_win_valid = 1'($urandom_range(0, 1));
      i_win_tdata = TD'({$urandom, $urandom, $urandom});
    end
    all_zero("reset");
    i_start = 1'b0;
    i_rst = 1'b0;
    idle();
    chk("idle_busy", 128'(o_busy), 128'(0));

    run_frame("full", 1'b0, -1, -1);
    idle();
    run_frame("bp", 1'b1, -1, -1);
    idle();
    run_frame("start_busy", 1'b0, 15, -1);
    idle();
    run_frame("abort", 1'b0, -1, 16 + 7);
    idle();
    run_frame("restart", 1'b0, -1, -1);
    idle();

    // default parameters: first pass address ramp only
    d_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    d_start = 1'b1;
    for (int k = 0; k < 49; k++) begin
      @(posedge clk);
      @(negedge clk);
      d_start = 1'b0;
      chk("dflt_rd", 128'(d_rd), 128'(1));
      chk("dflt_addr", 128'(d_addr), 128'(k));
    end
    @(posedge clk);
    @(negedge clk);
    chk("dflt_rd_after_load", 128'(d_rd), 128'(0));
    chk("dflt_busy", 128'(d_busy), 128'(1));
    d_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("dflt_rst_ctrl", 128'({d_busy, d_done, d_rd, d_ready, d_cw_vld, d_vsync, d_hsync, d_reuse, d_valid}), 128'(0));
    chk("dflt_rst_addr", 128'(d_addr), 128'(0));
    chk("dflt_rst_data", 128'({|d_cw, |d_tdata}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
